// File: rtl/gpmc_reg_bank.sv
// gpmc_reg_bank: register bank behind gpmc_sync. It holds the ID, the output
// port and the input sampling with sticky edge flags (W1C, per-bit polarity).
// It also drives a level interrupt and holds a block of scratch registers.
// All state resets synchronously when rst_n is low at a clock edge.
module gpmc_reg_bank #(
  parameter int                    ADDR_WIDTH  = 5,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    IN_WIDTH    = 2,
  parameter int                    OUT_WIDTH   = 4,
  parameter int                    NUM_SCRATCH = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 16'hBE1E
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [IN_WIDTH-1:0]   in_port,
  output logic [OUT_WIDTH-1:0]  out_port,
  output logic                  irq
);

  localparam logic [ADDR_WIDTH-1:0] A_ID    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_OUT   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_IN    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_FLAGS = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_POL   = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_IEN   = ADDR_WIDTH'(5);

  // One extra address bit so the scratch upper bound never wraps.
  localparam logic [ADDR_WIDTH:0] SCR_LO = (ADDR_WIDTH+1)'(8);
  localparam logic [ADDR_WIDTH:0] SCR_HI = (ADDR_WIDTH+1)'(8 + NUM_SCRATCH);
  localparam int                  SW     = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

  logic                  wr_stb;
  logic                  rd_stb;
  logic [ADDR_WIDTH:0]   addr_ext;
  logic                  scr_hit;
  logic [SW-1:0]         scr_idx;

  logic [OUT_WIDTH-1:0]  out_reg;
  logic [IN_WIDTH-1:0]   pol_reg;
  logic [IN_WIDTH-1:0]   ien_reg;
  logic [IN_WIDTH-1:0]   flags;
  logic [IN_WIDTH-1:0]   s1;
  logic [IN_WIDTH-1:0]   s2;
  logic [IN_WIDTH-1:0]   s3;
  logic [IN_WIDTH-1:0]   rise;
  logic [IN_WIDTH-1:0]   fall;
  logic [IN_WIDTH-1:0]   edge_hit;
  logic [IN_WIDTH-1:0]   flag_set;
  logic [IN_WIDTH-1:0]   flag_clr;
  logic [1:0]            arm_cnt;
  logic                  armed;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0] scratch [NUM_SCRATCH];

  // Both-low (we and oe) is neither a read nor a write.
  assign wr_stb = ~cs & ~we &  oe;
  assign rd_stb = ~cs &  we & ~oe;

  assign addr_ext = {1'b0, address};
  assign scr_hit  = (addr_ext >= SCR_LO) && (addr_ext < SCR_HI);
  assign scr_idx  = SW'(addr_ext - SCR_LO);

  assign out_port = out_reg;

  // Edge detection only looks at s2/s3, so changing POL on a static input
  // cannot create an edge.
  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign edge_hit = (rise & ~pol_reg) | (fall & pol_reg);
  assign armed    = (arm_cnt == 2'd0);
  assign flag_set = armed ? edge_hit : '0;
  assign flag_clr = (wr_stb && address == A_FLAGS) ? wdata[IN_WIDTH-1:0] : '0;

  // Control registers written by the host.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg <= '0;
      pol_reg <= '0;
      ien_reg <= '0;
    end else if (wr_stb) begin
      if (address == A_OUT) out_reg <= wdata[OUT_WIDTH-1:0];
      if (address == A_POL) pol_reg <= wdata[IN_WIDTH-1:0];
      if (address == A_IEN) ien_reg <= wdata[IN_WIDTH-1:0];
    end
  end

  // Scratch registers, full data width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else if (wr_stb && scr_hit) begin
      scratch[scr_idx] <= wdata;
    end
  end

  // Two-flop synchroniser plus history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Arm timer: counts down the three clocks needed to fill s1..s3 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arm_cnt <= 2'd3;
    end else if (!armed) begin
      arm_cnt <= arm_cnt - 2'd1;
    end
  end

  // Sticky flags: the clear is applied first, so a simultaneous set wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags <= '0;
    end else begin
      flags <= (flags & ~flag_clr) | flag_set;
    end
  end

  // Read mux over the current register contents.
  always_comb begin
    rd_val = '0;
    if (scr_hit) begin
      rd_val = scratch[scr_idx];
    end else begin
      case (address)
        A_ID:    rd_val = ID_VALUE;
        A_OUT:   rd_val = DATA_WIDTH'(out_reg);
        A_IN:    rd_val = DATA_WIDTH'(s2);
        A_FLAGS: rd_val = DATA_WIDTH'(flags);
        A_POL:   rd_val = DATA_WIDTH'(pol_reg);
        A_IEN:   rd_val = DATA_WIDTH'(ien_reg);
        default: rd_val = '0;
      endcase
    end
  end

  // Registered read data (zero when idle) and registered interrupt level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      rdata <= rd_stb ? rd_val : '0;
      irq   <= |(flags & ien_reg);
    end
  end

endmodule

// File: doc/gpmc_reg_bank.md
Name: gpmc_reg_bank

Overview:
Parametrised register bank for the FPGA side of the ARM–FPGA GPMC link. It sits behind the gpmc_sync controller and replaces an ad-hoc memory array that drove LEDs and read buttons. It provides:
- a read-only ID register,
- an output register that drives a port,
- synchronised input sampling,
- sticky edge-detect flags with write-1-to-clear and per-bit edge polarity,
- an interrupt output,
- a block of scratch registers.

Parameters:
ADDR_WIDTH, 5, width of register address from gpmc_sync; must satisfy 8+NUM_SCRATCH <= 2**ADDR_WIDTH
DATA_WIDTH, 16, register/data bus width
IN_WIDTH, 2, number of external inputs (buttons); 1..DATA_WIDTH
OUT_WIDTH, 4, number of external outputs (LEDs); 1..DATA_WIDTH
NUM_SCRATCH, 8, number of general read/write scratch registers
ID_VALUE, 16'hBE1E, constant returned at address 0 (truncated/zero-extended to DATA_WIDTH)

Ports:
clk  input  1  system clock; one clock domain, all logic on posedge
rst_n  input  1  reset, synchronous, active-low
cs  input  1  chip select from gpmc_sync, active-low
we  input  1  write enable from gpmc_sync, active-low
oe  input  1  output enable from gpmc_sync, active-low
address  input  ADDR_WIDTH  register address
wdata  input  DATA_WIDTH  host write data (gpmc_sync data_out)
rdata  output  DATA_WIDTH  registered read data to gpmc_sync data_in
in_port  input  IN_WIDTH  asynchronous external inputs
out_port  output  OUT_WIDTH  external outputs
irq  output  1  level interrupt, registered

Behaviour:
- Write strobe: cs==0 && we==0 && oe==1, qualified on every posedge clk.
- Read strobe: cs==0 && we==1 && oe==0.
- Neither or both-low: idle.
- Register map:
  - 0x0 ID: read-only, ID_VALUE.
  - 0x1 OUT: read/write; bits [OUT_WIDTH-1:0] drive out_port directly (no extra delay after register update).
  - 0x2 IN: read-only; synchronised inputs in bits [IN_WIDTH-1:0].
  - 0x3 FLAGS: sticky edge flags; writing 1 to a bit clears it, writing 0 has no effect.
  - 0x4 POL: read/write; bit i=0 selects rising edge on input i, 1 selects falling edge.
  - 0x5 IEN: read/write interrupt enable per flag.
  - 0x6–0x7: reserved, read 0, writes ignored.
  - 0x8..0x8+NUM_SCRATCH-1: scratch, read/write, full width.
  - Above that: read 0, writes ignored.
- Unused upper bits of narrow registers read 0; writes to them are ignored.
- Write timing: the register updates at the clock edge where the write strobe is sampled. A strobe held for multiple cycles rewrites the same value, which is harmless (W1C is idempotent).
- Read timing: rdata is registered. It equals the addressed register one clock after the read strobe is sampled, reflecting register contents at that edge. rdata is 0 on any cycle without a read strobe. Reads have no side effects.
- Input path: per bit, a 2-flop synchroniser (s1, s2) followed by history flop s3.
  - Rising edge on bit i = s2 & ~s3; falling edge = ~s2 & s3; POL selects which one applies.
  - An input change sampled into s1 at edge k is visible in IN after edge k+1, and its flag is set at edge k+2.
- Flag set/clear collision: if an edge and a W1C to the same bit occur in the same cycle, set wins and the flag stays 1.
- POL change: changing POL while an input is static must not set a flag. Edge detection uses s2/s3 only.
- Arming: after rst_n rises, flag setting is suppressed for the first 3 clocks while s1..s3 fill. This prevents a spurious edge on an input already high.
- IRQ: irq <= |(FLAGS & IEN), registered, so it updates one clock after the FLAGS/IEN change.
- Reset (rst_n==0 at posedge), which also aborts any in-progress access:
  - OUT, FLAGS, POL, IEN, scratch, s1..s3 are cleared to 0.
  - rdata = 0, irq = 0, out_port = 0.
  - The arm counter restarts.

Test Plan:
1. Reset, then read 0x0 -> rdata = 16'hBE1E one clock after the read strobe; all other outputs 0; rdata = 0 on idle cycles.
2. Write 0x1 = 16'hFFF5 -> out_port = 4'b0101 at the next edge; read 0x1 returns 16'h0005. Write 0x6 = 16'h1234 -> read 0x6 returns 0.
3. POL=0, IEN=1: in_port[0] 0->1 -> IN bit0 set after 2 clocks, FLAGS = 16'h0001 after 3 clocks, irq=1 one clock later. Write 0x3 = 16'h0001 -> FLAGS=0, then irq=0.
4. POL=16'h0002, in_port[1] 1->0 -> FLAGS bit1 set; a rising edge on bit1 sets nothing. W1C coinciding with a new edge on bit1 -> flag remains 1.
5. Hold in_port=2'b11 through reset release -> no flag set within 10 cycles after reset.
6. Write scratch 0x8..0xF with 16'hA000+i, read back all 8 -> exact match. Assert rst_n=0 mid-read -> rdata=0 next edge, and scratch reads 0 afterwards.
